cnt_seg_scan: RTL and testbench

//  Display stage directly downstream of the 4-bit binary counter.
//  - Samples the counter value on a load strobe.
//  - Converts it to BCD with a sequential double-dabble converter.
//  - Time-multiplexes the decimal digits onto a shared 7-segment bus

---
 rtl/cnt_seg_pkg.sv | 53 +++++
 rtl/bin2bcd_seq.sv | 70 +++++++
 rtl/cnt_seg_scan.sv | 124 ++++++++++++
 tb/tb_cnt_seg_scan.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seg_pkg.sv
// Shared definitions for the counter display stage: segment codes,
// converter state encoding and digit-count helper.
package cnt_seg_pkg;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } conv_state_e;

  // Active-high code for one BCD digit
  function automatic logic [6:0] seg7_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = SEG7_0;
      4'd1:    c = SEG7_1;
      4'd2:    c = SEG7_2;
      4'd3:    c = SEG7_3;
      4'd4:    c = SEG7_4;
      4'd5:    c = SEG7_5;
      4'd6:    c = SEG7_6;
      4'd7:    c = SEG7_7;
      4'd8:    c = SEG7_8;
      4'd9:    c = SEG7_9;
      default: c = SEG7_BLANK;
    endcase
    return c;
  endfunction

  function automatic int digits_needed(input int cnt_w);
    longint unsigned m;
    int d;
    m = (64'd1 << cnt_w) - 64'd1;
    d = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, W cycles.
// done pulses on the last shift; bcd is valid while done is high.
module bin2bcd_seq
  import cnt_seg_pkg::*;
#(
  parameter int W      = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SW = 4*DIGITS + W;
  localparam int CW = $clog2(W + 1);

  conv_state_e   state_q, state_d;
  logic [SW-1:0] work_q, work_d, adj;
  logic [CW-1:0] step_q, step_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    step_d  = step_q;
    done    = 1'b0;
    adj     = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[W+4*i +: 4] >= 4'd5)
        adj[W+4*i +: 4] = work_q[W+4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = {{(4*DIGITS){1'b0}}, bin};
          step_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = adj << 1;
        step_d = step_q + CW'(1);
        if (step_q == CW'(W - 1)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_SHIFT);
  assign bcd  = work_d[SW-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: rtl/cnt_seg_scan.sv
// Counter display stage: capture, BCD convert, scan onto 7-seg bus.
// Define LZ_BLANK_EN to darken leading-zero digits above digit 0.
module cnt_seg_scan
  import cnt_seg_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int DIGITS      = 2,
  parameter int SCAN_DIV    = 50000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              load,
  output logic              conv_busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_DARK =
    (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

  if (digits_needed(CNT_W) > DIGITS) begin : g_digits_chk
    $error("cnt_seg_scan: DIGITS too small for CNT_W");
  end
  if (SCAN_DIV < 1) begin : g_div_chk
    $error("cnt_seg_scan: SCAN_DIV must be >= 1");
  end

  logic                busy, done, start;
  logic [CNT_W-1:0]    bin;
  logic [4*DIGITS-1:0] bcd;

  logic                pend_q, pend_d;
  logic [CNT_W-1:0]    pval_q, pval_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [6:0]          code;
`ifdef LZ_BLANK_EN
  logic                lead;
`endif

  bin2bcd_seq #(
    .W      (CNT_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    start  = !busy && (load || pend_q);
    bin    = load ? cnt : pval_q;
    pend_d = pend_q;
    pval_d = pval_q;
    if (start)
      pend_d = 1'b0;
    // Loads during any shift cycle, including the last, wait here
    if (load && busy) begin
      pend_d = 1'b1;
      pval_d = cnt;
    end
    disp_d = done ? bcd : disp_q;
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    code = seg7_code(disp_q[{idx_q, 2'b00} +: 4]);
`ifdef LZ_BLANK_EN
    lead = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0)
        lead = 1'b0;
    end
    if (idx_q != '0 && lead)
      code = SEG7_BLANK;
`endif
    seg_d = (SEG_ACT_LOW != 0) ? ~code : code;
    dig_d = DIGITS'(1) << idx_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_q  <= 1'b0;
      pval_q  <= '0;
      disp_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_DARK;
      dig_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign conv_busy = busy;
  assign seg       = seg_q;
  assign dig_sel   = dig_q;

endmodule

// File: tb/tb_cnt_seg_scan.sv
// Scoreboard bench for cnt_seg_scan (SCAN_DIV=4, active-high segments).
// Compile with LZ_BLANK_EN to exercise leading-zero blanking.
module tb_cnt_seg_scan;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       load    = 1'b0;
  logic [3:0] cnt     = 4'd0;
  logic       conv_busy;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  always #5 sys_clk = ~sys_clk;

  cnt_seg_scan #(
    .CNT_W       (4),
    .DIGITS      (2),
    .SCAN_DIV    (4),
    .SEG_ACT_LOW (0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cnt       (cnt),
    .load      (load),
    .conv_busy (conv_busy),
    .seg       (seg),
    .dig_sel   (dig_sel)
  );

  typedef struct packed {
    logic [1:0] dig;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  localparam logic [6:0] SEGT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] tens_code(input int v);
`ifdef LZ_BLANK_EN
    if (v / 10 == 0) return 7'h00;
`endif
    return SEGT[v/10];
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    cnt  = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_conv(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge sys_clk);
      if (!conv_busy) idle = 1'b1;
    end
    if (!idle) begin
      miscompares++;
      $display("FAIL %s: conv_busy stuck high, wanted 0", name);
    end
    tick();
    tick();
  endtask

  task automatic expect_val(input int v);
    sb.push_back('{dig: 2'b01, seg: SEGT[v%10]});
    sb.push_back('{dig: 2'b10, seg: tens_code(v)});
    for (int i = 0; i < 60 && sb.size() > 0; i++)
      @(negedge sys_clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, wanted 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  // Monitor: compare the scoreboard head whenever its digit is enabled
  initial begin
    int age;
    age = 0;
    forever begin
      @(negedge sys_clk);
      if (sb.size() == 0) begin
        age = 0;
      end else if (dig_sel === sb[0].dig) begin
        vectors++;
        if (seg !== sb[0].seg) begin
          miscompares++;
          $display("FAIL seg dig=%b: got %h expected %h",
                   dig_sel, seg, sb[0].seg);
        end
        void'(sb.pop_front());
        age = 0;
      end else if (++age > 20) begin
        vectors++;
        miscompares++;
        $display("FAIL scan timeout: dig_sel=%b expected %b",
                 dig_sel, sb[0].dig);
        void'(sb.pop_front());
        age = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bcnt;
    logic [15:0] pat;
    logic [1:0]  ed;

    // 1: reset and initial scan cadence
    repeat (3) @(posedge sys_clk);
    #2;
    check("rst seg", 32'(seg), 32'h00);
    check("rst dig", 32'(dig_sel), 32'h0);
    check("rst busy", 32'(conv_busy), 32'h0);
    sys_rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge sys_clk);
      #2;
      ed = (((n - 1) / 4) % 2 != 0) ? 2'b10 : 2'b01;
      check("scan dig", 32'(dig_sel), 32'(ed));
      check("scan seg", 32'(seg),
            32'((ed == 2'b01) ? SEGT[0] : tens_code(0)));
    end

    // 2: single conversion of 13
    tick();
    pulse(4'd13);
    bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      bcnt += int'(conv_busy);
    end
    check("busy len 13", 32'(bcnt), 32'd4);
    tick();
    expect_val(13);

    // 3: 3 then pending 9 overwritten by 5
    cnt  = 4'd3;
    load = 1'b1;
    tick();
    fork
      begin
        cnt = 4'd9;
        tick();
        cnt = 4'd5;
        tick();
        load = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge sys_clk);
          pat[i] = conv_busy;
          if (dig_sel == 2'b01) begin
            if (i <= 9) check("t3 units=3", 32'(seg), 32'h4F);
            else        check("t3 units=5", 32'(seg), 32'h6D);
          end
        end
      end
    join
    check("t3 busy pattern", 32'(pat), 32'h01EF);
    tick();
    expect_val(5);

    // 4: sweep 3..15 then 0
    for (int v = 3; v <= 16; v++) begin
      pulse(4'(v % 16));
      wait_conv("sweep");
      expect_val(v % 16);
    end

    // 5: reset on the second shift cycle, with a load pending
    pulse(4'd11);
    wait_conv("pre-reset");
    expect_val(11);
    cnt  = 4'd12;
    load = 1'b1;
    tick();
    cnt = 4'd7;
    tick();
    load    = 1'b0;
    sys_rst = 1'b1;
    tick();
    check("t5 busy in rst", 32'(conv_busy), 32'h0);
    sys_rst = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      bcnt += int'(conv_busy);
    end
    check("t5 no restart", 32'(bcnt), 32'd0);
    tick();
    expect_val(0);

    // 6: small values (blanked tens when LZ_BLANK_EN)
    pulse(4'd5);
    wait_conv("lz5");
    expect_val(5);
    pulse(4'd0);
    wait_conv("lz0");
    expect_val(0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
